// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract unit: one full-adder step per clock, LSB first,
// with the carry held in a register between bits. Result and NZCV flags update on completion.
module serial_add_sub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Full adder cell on the current LSBs and the registered carry.
  logic             sum_bit;
  logic             cout;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    sum_bit  = a_sh[0] ^ b_sh[0] ^ carry;
    cout     = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    acc_next = {sum_bit, acc[WIDTH-1:1]};
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would chain the shift within one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers are cleared too, so a reset mid-op
      // leaves no stale partial sum or carry visible to the next operation.
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flags  <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= acc_next;
          carry <= cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // Carry into the MSB is the registered carry at this step, so V = carry ^ cout.
            result <= acc_next;
            flags  <= {sum_bit, (acc_next == '0), cout, carry ^ cout};
            done   <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: a 32-bit instance for the flag and handshake cases,
// and an 8-bit instance checked against a golden add/sub model.
module tb_serial_add_sub;

  logic        clk = 1'b0;
  logic        reset;

  logic        start32, sub32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [31:0] result32;
  logic [3:0]  flags32;

  logic        start8, sub8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [7:0]  result8;
  logic [3:0]  flags8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(result32), .flags(flags32)
  );

  serial_add_sub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .flags(flags8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one 32-bit op (start for a single cycle) and scrambles the operand
  // inputs afterwards; returns cycles from the start-driving edge to done and
  // the number of busy cycles seen.
  task automatic op32(input logic [31:0] ta, input logic [31:0] tb, input logic tsub,
                      input int pulse_at, output int lat, output int bcnt);
    @(posedge clk); #1;
    start32 = 1'b1; a32 = ta; b32 = tb; sub32 = tsub;
    lat = 0; bcnt = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      start32 = 1'b0;
      a32 = ~ta; b32 = ta ^ tb; sub32 = ~tsub;
      lat++;
      if (lat == pulse_at) begin
        start32 = 1'b1; a32 = 32'd100; b32 = 32'd100; sub32 = 1'b0;
      end
      @(negedge clk);
      if (busy32) bcnt++;
      if (done32) break;
    end
    if (lat >= 200) check("op32_timeout", 0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("op32_done_single", done32, 1'b0);
  endtask

  task automatic expect32(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tsub, input logic [31:0] eres, input logic [3:0] eflg);
    int lat, bcnt;
    op32(ta, tb, tsub, 0, lat, bcnt);
    check({tag, "_result"}, result32, eres);
    check({tag, "_flags"}, flags32, eflg);
    check({tag, "_latency"}, lat, 33);
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tsub, output int lat);
    @(posedge clk); #1;
    start8 = 1'b1; a8 = ta; b8 = tb; sub8 = tsub;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk); #1;
      start8 = 1'b0; a8 = $urandom(); b8 = $urandom(); sub8 = $urandom();
      lat++;
      @(negedge clk);
      if (done8) break;
    end
    if (lat >= 50) check("op8_timeout", 0, 1);
  endtask

  initial begin
    int lat, bcnt, pulses, last, prev, waitc;
    logic [8:0] s9;
    logic [7:0] ra, rb, eres;
    logic       rs, ev;

    reset = 1'b1;
    start32 = 1'b0; sub32 = 1'b0; a32 = '0; b32 = '0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy32, 1'b0);
    check("rst_done", done32, 1'b0);
    check("rst_result", result32, 32'h0);
    check("rst_flags", flags32, 4'b0000);
    #1 reset = 1'b0;

    op32(32'd5, 32'd3, 1'b0, 0, lat, bcnt);
    check("add_result", result32, 32'h0000_0008);
    check("add_flags", flags32, 4'b0000);
    check("add_latency", lat, 33);
    check("add_busy_cycles", bcnt, 33);
    @(negedge clk);
    check("add_busy_after", busy32, 1'b0);

    expect32("carry_zero", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 4'b0110);
    expect32("ovf_add", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 4'b1001);
    expect32("sub_eq", 32'd5, 32'd5, 1'b1, 32'h0, 4'b0110);
    expect32("sub_neg", 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 4'b1000);
    expect32("sub_ovf", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 4'b0011);

    // A second start during RUN must be dropped, not queued.
    op32(32'd5, 32'd3, 1'b0, 5, lat, bcnt);
    check("ign_result", result32, 32'h8);
    check("ign_latency", lat, 33);
    @(posedge clk); #1 start32 = 1'b0;
    waitc = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy32) waitc++;
      @(posedge clk);
    end
    check("ign_no_second_op", waitc, 0);

    // Reset five cycles into an op: abort with cleared outputs and no done.
    @(posedge clk); #1;
    start32 = 1'b1; a32 = 32'h1234; b32 = 32'h1; sub32 = 1'b0;
    @(posedge clk); #1 start32 = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy32, 1'b0);
    check("abort_result", result32, 32'h0);
    check("abort_flags", flags32, 4'b0000);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32 || busy32) pulses++;
    end
    check("abort_no_done", pulses, 0);

    // Start held high: back-to-back ops every WIDTH+2 cycles, single-cycle done.
    @(posedge clk); #1;
    start32 = 1'b1; a32 = 32'd10; b32 = 32'd4; sub32 = 1'b1;
    pulses = 0; last = -1; prev = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done32) begin
        pulses++;
        check("b2b_result", result32, 32'd6);
        if (last >= 0) check("b2b_period", i - last, 34);
        last = i;
      end
      if (done32 && prev) check("b2b_single_pulse", 0, 1);
      prev = done32;
    end
    check("b2b_pulses", pulses, 2);
    #1 start32 = 1'b0;
    waitc = 0;
    while (busy32 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check("b2b_drain", busy32, 1'b0);

    // 8-bit sweep against the golden add/sub model.
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom(); rb = $urandom(); rs = $urandom();
      if (n == 0) begin ra = 8'h80; rb = 8'h01; rs = 1'b1; end
      if (n == 1) begin ra = 8'hFF; rb = 8'hFF; rs = 1'b0; end
      s9   = rs ? ({1'b0, ra} + {1'b0, ~rb} + 9'd1) : ({1'b0, ra} + {1'b0, rb});
      eres = s9[7:0];
      ev   = rs ? ((ra[7] != rb[7]) && (eres[7] != ra[7]))
                : ((ra[7] == rb[7]) && (eres[7] != ra[7]));
      op8(ra, rb, rs, lat);
      check("w8_op", {result8, flags8}, {eres, eres[7], (eres == 8'h0), s9[8], ev});
      if (n < 4) check("w8_latency", lat, 9);
    end

    // Held start on the 8-bit unit: done-to-done period of 10 cycles.
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd2; sub8 = 1'b0;
    last = -1; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        pulses++;
        if (last >= 0) check("w8_period", i - last, 10);
        last = i;
      end
    end
    check("w8_pulses", pulses, 3);
    #1 start8 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
